dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that is the responder on the MEM stage's cache interface (cache_rd/cache_wr/cache_addr/cache_wr_data/cache_wr_be with cache_waitrequest back-pressure). It answers read hits in the same cycle and refills missing lines word by word over a single-outstanding memory master port. It forwards every store to memory. It sits between the MEM stage and the system memory/interconnect.

---
 rtl/dcache_if.sv | 37 +++
 rtl/dcache.sv | 188 ++++++++++++++++++
 tb/tb_dcache.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// Cache bus between the MEM stage and the data cache, plus the cache's memory master port.
// The slave modport is the cache's view; master is the environment (requester + memory).
interface dcache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                      cache_rd;
    logic                      cache_wr;
    logic [ADDR_WIDTH-1:0]     cache_addr;
    logic [DATA_WIDTH-1:0]     cache_wr_data;
    logic [DATA_WIDTH/8-1:0]   cache_wr_be;
    logic [DATA_WIDTH-1:0]     cache_data;
    logic                      cache_waitrequest;

    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_rd;
    logic                      mem_wr;
    logic [DATA_WIDTH-1:0]     mem_wr_data;
    logic [DATA_WIDTH/8-1:0]   mem_wr_be;
    logic [DATA_WIDTH-1:0]     mem_rd_data;
    logic                      mem_rd_valid;
    logic                      mem_waitrequest;

    modport slave (
        input  cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
        output cache_data, cache_waitrequest,
        output mem_addr, mem_rd, mem_wr, mem_wr_data, mem_wr_be,
        input  mem_rd_data, mem_rd_valid, mem_waitrequest
    );

    modport master (
        output cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
        input  cache_data, cache_waitrequest,
        input  mem_addr, mem_rd, mem_wr, mem_wr_data, mem_wr_be,
        output mem_rd_data, mem_rd_valid, mem_waitrequest
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache. Read hits answer in the
// request cycle; misses refill the line one word at a time over a single-outstanding port.
module dcache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    dcache_if.slave bus
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int OB   = $clog2(LINE_WORDS);
    localparam int IB   = $clog2(NUM_LINES);
    localparam int TB   = ADDR_WIDTH - IB - OB - 2;
    localparam int LW   = ADDR_WIDTH - OB - 2;
    localparam int WW   = ADDR_WIDTH - 2;
    localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     line_q, line_d;
    logic [OB-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   wbe_q, wbe_d;

    logic [NUM_LINES-1:0]  valid_q;
    logic [TB-1:0]         tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES*LINE_WORDS];

    logic [IB-1:0] req_idx, wr_idx, fill_idx;
    logic [OB-1:0] req_off, wr_off;
    logic [TB-1:0] req_tag, wr_tag, fill_tag;
    logic          req_hit, wr_hit;
    logic [DATA_WIDTH-1:0] wr_cur_word, wr_merged;

    logic fill_we, fill_done, merge_we;
    logic cache_wait;
    logic [DATA_WIDTH-1:0] cache_rdata;
    logic mem_rd, mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [BE_W-1:0] mem_wr_be;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus.cache_addr[1:0];

    assign req_off  = bus.cache_addr[2 +: OB];
    assign req_idx  = bus.cache_addr[OB+2 +: IB];
    assign req_tag  = bus.cache_addr[ADDR_WIDTH-1 -: TB];
    assign wr_off   = waddr_q[0 +: OB];
    assign wr_idx   = waddr_q[OB +: IB];
    assign wr_tag   = waddr_q[WW-1 -: TB];
    assign fill_idx = line_q[0 +: IB];
    assign fill_tag = line_q[LW-1 -: TB];

    assign req_hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_cur_word = data_q[{wr_idx, wr_off}];

    // Store hits keep the unenabled bytes of the cached word.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
        assign wr_merged[8*gi +: 8] = wbe_q[gi] ? wdata_q[8*gi +: 8] : wr_cur_word[8*gi +: 8];
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        cnt_d       = cnt_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wbe_d       = wbe_q;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        merge_we    = 1'b0;
        cache_wait  = 1'b0;
        cache_rdata = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_be   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.cache_wr) begin
                    cache_wait = 1'b1;
                    waddr_d    = bus.cache_addr[ADDR_WIDTH-1:2];
                    wdata_d    = bus.cache_wr_data;
                    wbe_d      = bus.cache_wr_be;
                    state_d    = S_WRITE;
                end else if (bus.cache_rd) begin
                    if (req_hit) begin
                        cache_rdata = data_q[{req_idx, req_off}];
                    end else begin
                        cache_wait = 1'b1;
                        line_d     = bus.cache_addr[ADDR_WIDTH-1:OB+2];
                        cnt_d      = '0;
                        state_d    = S_REFILL_REQ;
                    end
                end
            end
            S_REFILL_REQ: begin
                cache_wait = 1'b1;
                mem_rd     = 1'b1;
                mem_addr   = {line_q, cnt_q, 2'b00};
                if (!bus.mem_waitrequest) begin
                    state_d = S_REFILL_WAIT;
                end
            end
            S_REFILL_WAIT: begin
                cache_wait = 1'b1;
                if (bus.mem_rd_valid) begin
                    fill_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        // Line becomes visible only once every word is in place.
                        fill_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + OB'(1);
                        state_d = S_REFILL_REQ;
                    end
                end
            end
            S_WRITE: begin
                cache_wait  = bus.mem_waitrequest;
                mem_wr      = 1'b1;
                mem_addr    = {waddr_q, 2'b00};
                mem_wr_data = wdata_q;
                mem_wr_be   = wbe_q;
                if (!bus.mem_waitrequest) begin
                    merge_we = wr_hit;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wbe_q   <= wbe_d;
            if (fill_done) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q alone decides what can hit.
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
        if (fill_we) begin
            data_q[{fill_idx, cnt_q}] <= bus.mem_rd_data;
        end else if (merge_we) begin
            data_q[{wr_idx, wr_off}] <= wr_merged;
        end
    end

    assign bus.cache_waitrequest = cache_wait;
    assign bus.cache_data        = cache_rdata;
    assign bus.mem_rd            = mem_rd;
    assign bus.mem_wr            = mem_wr;
    assign bus.mem_addr          = mem_addr;
    assign bus.mem_wr_data       = mem_wr_data;
    assign bus.mem_wr_be         = mem_wr_be;
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: a vector table of cache transactions against a simple
// word memory, plus hand-written sequences for write back-pressure and mid-refill reset.
module tb_dcache;
    logic clk;
    logic rst;

    dcache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dcache #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_LINES (64),
        .LINE_WORDS(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Memory: untouched words in line 0x1230 hold 0xA0+i, elsewhere 0xC0DE_<addr[15:0]>.
    logic [31:0] mem_a [logic [31:0]];
    logic [31:0] rd_log [$];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        if (a[31:4] == 28'h0000123) return 32'hA0 + {28'h0, a[3:2]};
        return {16'hC0DE, a[15:0]};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            bus.mem_rd_valid = pend;
            bus.mem_rd_data  = pend_data;
            pend = 1'b0;
            if (bus.mem_rd && !bus.mem_waitrequest) begin
                pend      = 1'b1;
                pend_data = mem_read(bus.mem_addr);
                rd_log.push_back(bus.mem_addr);
                rd_cnt++;
            end
            if (bus.mem_wr && !bus.mem_waitrequest) begin
                logic [31:0] w;
                w = mem_read(bus.mem_addr);
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wr_be[b]) w[8*b +: 8] = bus.mem_wr_data[8*b +: 8];
                mem_a[bus.mem_addr] = w;
                wr_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge; holds the request until waitrequest drops.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output int lat, output logic [31:0] d);
        bus.cache_rd      = rd;
        bus.cache_wr      = wr;
        bus.cache_addr    = a;
        bus.cache_wr_data = wd;
        bus.cache_wr_be   = be;
        #1;
        lat = 0;
        while (bus.cache_waitrequest && lat < 200) begin
            @(posedge clk);
            #2;
            lat++;
        end
        d = bus.cache_data;
        @(posedge clk);
        #1;
        bus.cache_rd = 1'b0;
        bus.cache_wr = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          exp_lat;
        logic [31:0] exp_data;
        int          exp_rds;
        int          exp_wrs;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int          lat;
        logic [31:0] d;
        int          r0, w0;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,          4'h0, 9, 32'h0000_00A1, 4, 0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_1238, 32'h0,          4'h0, 0, 32'h0000_00A2, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_123C, 32'h0,          4'h0, 0, 32'h0000_00A3, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_1234, 32'h0000_55FF,  4'h3, 1, 32'h0,         0, 1};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,          4'h0, 0, 32'h0000_55FF, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_8000, 32'hDEAD_BEEF,  4'hF, 1, 32'h0,         0, 1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_8000, 32'h0,          4'h0, 9, 32'hDEAD_BEEF, 4, 0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_1634, 32'h0,          4'h0, 9, 32'hC0DE_1634, 4, 0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,          4'h0, 9, 32'h0000_55FF, 4, 0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_1630, 32'h0,          4'h0, 9, 32'hC0DE_1630, 4, 0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_1630, 32'h1122_3344,  4'hC, 1, 32'h0,         0, 1};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_1630, 32'h0,          4'h0, 0, 32'h1122_1630, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_1234, 32'h00AA_0000,  4'h4, 1, 32'h0,         0, 1};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0,          4'h0, 9, 32'h00AA_55FF, 4, 0};

        rst = 1'b1;
        bus.cache_rd = 1'b0;
        bus.cache_wr = 1'b0;
        bus.cache_addr = '0;
        bus.cache_wr_data = '0;
        bus.cache_wr_be = '0;
        bus.mem_rd_data = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_waitreq",  {31'h0, bus.cache_waitrequest}, 32'h0);
        chk("rst_mem_rd",   {31'h0, bus.mem_rd}, 32'h0);
        chk("rst_mem_wr",   {31'h0, bus.mem_wr}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_data", bus.mem_wr_data, 32'h0);
        chk("rst_mem_be",   {28'h0, bus.mem_wr_be}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            r0 = rd_cnt;
            w0 = wr_cnt;
            txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, d);
            $display("vec %0d rd=%0b wr=%0b addr=%h lat=%0d data=%h mem_rd=%0d mem_wr=%0d",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].addr, lat, d, rd_cnt - r0, wr_cnt - w0);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].rd && !vecs[i].wr)
                chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_mem_rds", i), rd_cnt - r0, vecs[i].exp_rds);
            chk($sformatf("vec%0d_mem_wrs", i), wr_cnt - w0, vecs[i].exp_wrs);
        end

        // Cold refill of 0x1234 must fetch the line in word order.
        for (int k = 0; k < 4; k++)
            chk($sformatf("refill_order_%0d", k), (rd_log.size() > k) ? rd_log[k] : 32'hFFFF_FFFF,
                32'h0000_1230 + 32'(4 * k));

        // Store hit with memory stalling three cycles in WRITE.
        w0 = wr_cnt;
        bus.mem_waitrequest = 1'b1;
        bus.cache_wr      = 1'b1;
        bus.cache_addr    = 32'h0000_1238;
        bus.cache_wr_data = 32'h1234_5678;
        bus.cache_wr_be   = 4'hF;
        #1;
        chk("stall_c0_waitreq", {31'h0, bus.cache_waitrequest}, 32'h1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #2;
            chk($sformatf("stall_c%0d_mem_wr", k),   {31'h0, bus.mem_wr}, 32'h1);
            chk($sformatf("stall_c%0d_mem_addr", k), bus.mem_addr, 32'h0000_1238);
            chk($sformatf("stall_c%0d_mem_data", k), bus.mem_wr_data, 32'h1234_5678);
            chk($sformatf("stall_c%0d_mem_be", k),   {28'h0, bus.mem_wr_be}, 32'hF);
            chk($sformatf("stall_c%0d_waitreq", k),  {31'h0, bus.cache_waitrequest}, 32'h1);
        end
        @(posedge clk);
        #1;
        bus.mem_waitrequest = 1'b0;
        #1;
        chk("stall_release_waitreq", {31'h0, bus.cache_waitrequest}, 32'h0);
        chk("stall_release_mem_wr",  {31'h0, bus.mem_wr}, 32'h1);
        @(posedge clk);
        #1;
        bus.cache_wr = 1'b0;
        $display("stall write addr=00001238 mem_wr=%0d", wr_cnt - w0);
        chk("stall_mem_wrs", wr_cnt - w0, 1);
        txn(1'b1, 1'b0, 32'h0000_1238, 32'h0, 4'h0, lat, d);
        $display("read after stall addr=00001238 lat=%0d data=%h", lat, d);
        chk("stall_readback_lat",  lat, 0);
        chk("stall_readback_data", d, 32'h1234_5678);

        // Reset during a refill; the late response must be ignored.
        bus.cache_rd   = 1'b1;
        bus.cache_addr = 32'h0000_2000;
        #1;
        chk("rstmid_c0_waitreq", {31'h0, bus.cache_waitrequest}, 32'h1);
        @(posedge clk);
        #1;
        chk("rstmid_c1_mem_rd",   {31'h0, bus.mem_rd}, 32'h1);
        chk("rstmid_c1_mem_addr", bus.mem_addr, 32'h0000_2000);
        #5;
        rst = 1'b1;
        #1;
        chk("rstmid_mem_rd_drop",   {31'h0, bus.mem_rd}, 32'h0);
        chk("rstmid_mem_addr_drop", bus.mem_addr, 32'h0);
        bus.cache_rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("rstmid_idle_waitreq", {31'h0, bus.cache_waitrequest}, 32'h0);
        chk("rstmid_idle_mem_rd",  {31'h0, bus.mem_rd}, 32'h0);
        r0 = rd_cnt;
        txn(1'b1, 1'b0, 32'h0000_1234, 32'h0, 4'h0, lat, d);
        $display("post-reset read addr=00001234 lat=%0d data=%h mem_rd=%0d", lat, d, rd_cnt - r0);
        chk("rstmid_1234_lat",  lat, 9);
        chk("rstmid_1234_data", d, 32'h00AA_55FF);
        chk("rstmid_1234_rds",  rd_cnt - r0, 4);
        r0 = rd_cnt;
        txn(1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'h0, lat, d);
        $display("post-reset read addr=00008000 lat=%0d data=%h mem_rd=%0d", lat, d, rd_cnt - r0);
        chk("rstmid_8000_lat",  lat, 9);
        chk("rstmid_8000_data", d, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
